// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared encodings for the pipeline hazard controller.
package pipe_ctrl_pkg;
    localparam logic [1:0] FWD_REG      = 2'd0;
    localparam logic [1:0] FWD_EXE      = 2'd1;
    localparam logic [1:0] FWD_MEM_ALU  = 2'd2;
    localparam logic [1:0] FWD_MEM_LOAD = 2'd3;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EXE = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;
    localparam int NUM_STG = 5;

    // EXE result beats MEM result; a MEM hit picks load data or ALU result.
    function automatic logic [1:0] fwd_sel(input logic exe_hit, input logic mem_hit, input logic mem_load);
        return exe_hit ? FWD_EXE : mem_hit ? (mem_load ? FWD_MEM_LOAD : FWD_MEM_ALU) : FWD_REG;
    endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_step_sync.sv
// step_sync: synchronises the asynchronous debug_step input and emits a one-clk pulse per rising edge.
module step_sync (
    input  logic clk,
    input  logic rst,
    input  logic step,
    output logic pulse
);
    logic [2:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr    <= '0;
            pulse <= 1'b0;
        end else begin
            sr    <= {sr[1:0], step};
            pulse <= sr[1] & ~sr[2];
        end
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage MIPS pipeline control - hazards, forwarding, memory-wait stalls,
// branch flush and debug single-step gating, plus performance counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int FWD_EN     = 1,
    parameter int DELAY_SLOT = 1,
    parameter int DEBUG_EN   = 1,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  debug_en,
    input  logic                  debug_step,
    input  logic                  inst_ack,
    input  logic                  mem_ack,
    input  logic [REG_ADDR_W-1:0] id_rs_addr,
    input  logic [REG_ADDR_W-1:0] id_rt_addr,
    input  logic                  id_rs_used,
    input  logic                  id_rt_used,
    input  logic                  id_wb_wen,
    input  logic [REG_ADDR_W-1:0] id_regw_addr,
    input  logic                  id_mem_ren,
    input  logic                  id_mem_wen,
    input  logic                  id_branch_taken,
    input  logic                  cnt_clr,
    output logic                  if_en,
    output logic                  id_en,
    output logic                  exe_en,
    output logic                  mem_en,
    output logic                  wb_en,
    output logic                  if_rst,
    output logic                  id_rst,
    output logic                  exe_rst,
    output logic                  mem_rst,
    output logic                  wb_rst,
    output logic                  if_valid,
    output logic                  id_valid,
    output logic                  exe_valid,
    output logic                  mem_valid,
    output logic                  wb_valid,
    output logic [1:0]            fwd_a_ctrl,
    output logic [1:0]            fwd_b_ctrl,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic [CNT_W-1:0]      retire_cnt
);
    logic step_pulse, advance, stall_id, mem_hold, if_hold, flush;
    logic [NUM_STG-1:0] en_c, rst_c;
    logic id_v, exe_v, exe_wen, exe_ren, exe_acc, mem_v, mem_wen, mem_ren, mem_acc, wb_v, wb_wen;
    logic [REG_ADDR_W-1:0] exe_addr, mem_addr, wb_addr;
    logic exe_a, exe_b, mem_a, mem_b, wb_a, wb_b;

    function automatic logic hit(input logic v, input logic w, input logic [REG_ADDR_W-1:0] a,
                                 input logic u, input logic [REG_ADDR_W-1:0] x);
        return v & w & (a != '0) & u & (x == a);
    endfunction

    step_sync u_step_sync (
        .clk   (clk),
        .rst   (rst),
        .step  (debug_step),
        .pulse (step_pulse)
    );

    assign exe_a = hit(exe_v, exe_wen, exe_addr, id_rs_used, id_rs_addr);
    assign exe_b = hit(exe_v, exe_wen, exe_addr, id_rt_used, id_rt_addr);
    assign mem_a = hit(mem_v, mem_wen, mem_addr, id_rs_used, id_rs_addr);
    assign mem_b = hit(mem_v, mem_wen, mem_addr, id_rt_used, id_rt_addr);
    assign wb_a  = hit(wb_v, wb_wen, wb_addr, id_rs_used, id_rs_addr);
    assign wb_b  = hit(wb_v, wb_wen, wb_addr, id_rt_used, id_rt_addr);

    assign advance  = (DEBUG_EN == 0) | ~debug_en | step_pulse;
    assign stall_id = (FWD_EN != 0) ? ((exe_a | exe_b) & exe_ren) : (exe_a | exe_b | mem_a | mem_b | wb_a | wb_b);
    assign mem_hold = mem_v & mem_acc & ~mem_ack;
    assign if_hold  = ~inst_ack;
    assign flush    = en_c[STG_ID] & ~stall_id & id_branch_taken & (DELAY_SLOT == 0);

    always_comb begin
        en_c[STG_WB]   = advance;
        en_c[STG_MEM]  = advance & ~mem_hold;
        en_c[STG_EXE]  = en_c[STG_MEM];
        en_c[STG_ID]   = en_c[STG_MEM];
        en_c[STG_IF]   = en_c[STG_ID] & ~stall_id & ~if_hold;
        rst_c[STG_WB]  = advance & mem_hold;
        rst_c[STG_MEM] = 1'b0;
        rst_c[STG_EXE] = en_c[STG_EXE] & stall_id;
        rst_c[STG_ID]  = en_c[STG_ID] & ~stall_id & (if_hold | flush);
        rst_c[STG_IF]  = 1'b0;
    end

    assign {wb_en, mem_en, exe_en, id_en, if_en}      = en_c & {NUM_STG{~rst}};
    assign {wb_rst, mem_rst, exe_rst, id_rst, if_rst} = rst_c | {NUM_STG{rst}};
    // IF always holds a real fetch once out of reset.
    assign if_valid  = ~rst;
    assign id_valid  = id_v;
    assign exe_valid = exe_v;
    assign mem_valid = mem_v;
    assign wb_valid  = wb_v;

    assign fwd_a_ctrl = (FWD_EN != 0) ? fwd_sel(exe_a & ~exe_ren, mem_a, mem_ren) : FWD_REG;
    assign fwd_b_ctrl = (FWD_EN != 0) ? fwd_sel(exe_b & ~exe_ren, mem_b, mem_ren) : FWD_REG;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {id_v, exe_v, exe_wen, exe_ren, exe_acc, mem_v, mem_wen, mem_ren, mem_acc, wb_v, wb_wen} <= '0;
            exe_addr <= '0;
            mem_addr <= '0;
            wb_addr  <= '0;
        end else begin
            if (en_c[STG_ID])
                id_v <= ~rst_c[STG_ID];
            if (en_c[STG_EXE]) begin
                exe_v    <= ~rst_c[STG_EXE] & id_v;
                exe_wen  <= ~rst_c[STG_EXE] & id_wb_wen;
                exe_addr <= rst_c[STG_EXE] ? '0 : id_regw_addr;
                exe_ren  <= ~rst_c[STG_EXE] & id_mem_ren;
                exe_acc  <= ~rst_c[STG_EXE] & (id_mem_ren | id_mem_wen);
            end
            if (en_c[STG_MEM]) begin
                mem_v    <= exe_v;
                mem_wen  <= exe_wen;
                mem_addr <= exe_addr;
                mem_ren  <= exe_ren;
                mem_acc  <= exe_acc;
            end
            if (en_c[STG_WB]) begin
                wb_v    <= ~rst_c[STG_WB] & mem_v;
                wb_wen  <= ~rst_c[STG_WB] & mem_wen;
                wb_addr <= rst_c[STG_WB] ? '0 : mem_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst | cnt_clr) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            retire_cnt <= '0;
        end else if (advance) begin
            stall_cnt  <= stall_cnt + CNT_W'(stall_id | mem_hold | if_hold);
            flush_cnt  <= flush_cnt + CNT_W'(flush);
            retire_cnt <= retire_cnt + CNT_W'(wb_v);
        end
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised pipeline control unit for the 5-stage MIPS core (IF/ID/EXE/MEM/WB); successor to the fixed single-cycle-memory stage controller. It keeps its own per-stage valid and hazard shadow registers, and detects load-use and RAW hazards. It generates per-stage en/rst/valid, ID-stage forwarding selects, branch-flush or delay-slot handling, multi-cycle instruction/data memory wait stalls and debug single-step gating. Sits inside mips_core beside the controller and drives the datapath stage registers.

Parameters:
REG_ADDR_W, 5, register address width
FWD_EN, 1, 1 = forwarding plus load-use stall; 0 = stall on any RAW
DELAY_SLOT, 1, 1 = MIPS delay slot (no flush); 0 = flush IF instruction on taken branch
DEBUG_EN, 1, 0 = debug_en/debug_step ignored, advance every cycle
CNT_W, 32, performance counter width

Ports:
clk  in  1  main clock
rst  in  1  reset
debug_en  in  1  single-step mode
debug_step  in  1  step button/clock, asynchronous to clk
inst_ack  in  1  instruction fetch complete this cycle
mem_ack  in  1  data access complete this cycle
id_rs_addr, id_rt_addr  in  REG_ADDR_W  ID source registers
id_rs_used, id_rt_used  in  1  source actually read
id_wb_wen  in  1  ID instruction writes the register file
id_regw_addr  in  REG_ADDR_W  ID destination
id_mem_ren, id_mem_wen  in  1  ID instruction is load/store
id_branch_taken  in  1  taken branch/jump resolved in ID
cnt_clr  in  1  synchronous counter clear
if_en, id_en, exe_en, mem_en, wb_en  out  1  stage register load enable
if_rst, id_rst, exe_rst, mem_rst, wb_rst  out  1  load bubble into stage register
if_valid, id_valid, exe_valid, mem_valid, wb_valid  out  1  stage holds a real instruction
fwd_a_ctrl, fwd_b_ctrl  out  2  ID operand select: 0 regfile, 1 EXE ALU, 2 MEM ALU, 3 MEM load data
stall_cnt, flush_cnt, retire_cnt  out  CNT_W  performance counters

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset: all valid/shadow registers, counters and step synchroniser to 0; all *_rst=1, all *_en=0 while rst high; fwd_*=0. First cycle after release: if_valid=1, other stage valids 0.
- advance = ~DEBUG_EN | ~debug_en | step_pulse. step_pulse is a one-clk pulse on the rising edge of debug_step, via a 2-FF synchroniser plus edge detect; latency 3 clk.
- Shadows per EXE/MEM/WB: valid, wen, regw_addr, mem_ren, mem_acc (ren|wen). Each loads from the previous stage when that stage's en is high. It loads 0 when that stage's rst is high.
- match(s,x) = s_valid & s_wen & s_addr!=0 & x_used & x_addr==s_addr. Register 0 never matches.
- stall_id: FWD_EN=1: match(EXE,rs|rt) & exe_mem_ren. FWD_EN=0: any match in EXE, MEM or WB.
- mem_hold = mem_valid & mem_mem_acc & ~mem_ack. if_hold = ~inst_ack.
- wb_en = advance. mem_en = exe_en = advance & ~mem_hold. id_en = exe_en. if_en = id_en & ~stall_id & ~if_hold.
- wb_rst = advance & mem_hold. exe_rst = exe_en & stall_id.
- id_rst = id_en & ~stall_id & (if_hold | (id_branch_taken & ~DELAY_SLOT)).
- During stall_id, ID holds its instruction (id register not reloaded, id_rst=0).
- Simultaneous mem_hold and stall_id: mem_hold dominates (everything below WB frozen). Branch during stall_id: no flush until the stall clears.
- fwd_x (FWD_EN=1), priority EXE over MEM: match(EXE,x) & ~exe_mem_ren -> 1. match(MEM,x) -> 3 if mem_mem_ren, else 2. Otherwise 0. WB relies on regfile write-before-read. FWD_EN=0: fwd_* = 0.
- Counters, on cycles where advance=1, wrap at 2^CNT_W:
  - stall_cnt += (stall_id | mem_hold | if_hold)
  - flush_cnt += flush event
  - retire_cnt += wb_valid
- cnt_clr zeroes all counters next edge and wins over increment.

Decomposition:
- Package pipe_ctrl_pkg: FWD_REG/FWD_EXE/FWD_MEM_ALU/FWD_MEM_LOAD encodings and stage index constants.
- Sub-module step_sync: synchroniser plus edge detect for debug_step.
- Counters inline.

Test Plan:
- Reset mid-run with stages full, then release: all *_valid drop immediately; after release if_valid=1, others 0, counters 0.
- Load to r5 in EXE, ID reads rs=r5: exe_rst=1, if_en=0 for exactly 1 cycle. Next cycle fwd_a_ctrl=3, stall_cnt=1.
- ADD r3 in EXE, ID uses rt=r3; separately ADD r0 in EXE, ID uses r0: fwd_b_ctrl=1 in the first case, fwd=0 in the r0 case.
- mem_ack low 3 cycles with a load in MEM: mem_en=0 and wb_rst=1 for 3 cycles, stall_cnt=3, no instruction lost.
- DELAY_SLOT=0, id_branch_taken=1: id_rst=1 one cycle, flush_cnt=1. DELAY_SLOT=1: id_rst=0.
- debug_en=1 with no steps: all en=0. Two debug_step pulses: exactly 2 advance cycles, retire_cnt reflects only WB-valid ones.
